// File: rtl/run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// run_ctrl_pkg
// Shared types and helpers for the run controller / register dump block.
//   run_state_e  : controller phase (RUN -> DRAIN -> DUMP -> DONE)
//   halt_cause_e : latched reason the run stopped
//   idx_width()  : counter width helper that never returns 0
// -----------------------------------------------------------------------------
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DUMP  = 2'd2,
    DONE  = 2'd3
  } run_state_e;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    TIMEOUT  = 2'd1,
    SELFLOOP = 2'd2,
    EXTERNAL = 2'd3
  } halt_cause_e;

  // Width of a counter holding values 0..n-1; at least one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/run_ctrl_dump_pc_loop_detect.sv
// -----------------------------------------------------------------------------
// pc_loop_detect
// Flags the SELF_LOOP_N-th consecutive identical retired PC.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   pc_i        : PC of the retiring instruction
//   pc_valid_i  : pc_i is valid this cycle
//   loop_hit    : combinational; high in the cycle the N-th identical PC retires
// -----------------------------------------------------------------------------
module pc_loop_detect
  import run_ctrl_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned SELF_LOOP_N = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_valid_i,
  output logic            loop_hit
);

  localparam int unsigned   CW      = idx_width(SELF_LOOP_N);
  localparam logic [CW-1:0] HIT_CNT = CW'(SELF_LOOP_N - 2);

  logic            last_valid_q, last_valid_d;
  logic [XLEN-1:0] last_pc_q,    last_pc_d;
  logic [CW-1:0]   loop_cnt_q,   loop_cnt_d;
  logic            pc_match;

  // The first valid PC after reset cannot match: last_valid_q is still clear.
  assign pc_match = pc_valid_i && last_valid_q && (pc_i == last_pc_q);
  assign loop_hit = pc_match && (loop_cnt_q == HIT_CNT);

  always_comb begin
    last_valid_d = last_valid_q;
    last_pc_d    = last_pc_q;
    loop_cnt_d   = loop_cnt_q;
    if (pc_valid_i) begin
      last_valid_d = 1'b1;
      last_pc_d    = pc_i;
      if (pc_match) begin
        // Hold at the hit value so the count never wraps back to a miss.
        if (loop_cnt_q != HIT_CNT) loop_cnt_d = loop_cnt_q + CW'(1);
      end else begin
        loop_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_valid_q <= 1'b0;
      last_pc_q    <= '0;
      loop_cnt_q   <= '0;
    end else begin
      last_valid_q <= last_valid_d;
      last_pc_q    <= last_pc_d;
      loop_cnt_q   <= loop_cnt_d;
    end
  end

endmodule

// File: rtl/run_ctrl_dump.sv
// -----------------------------------------------------------------------------
// run_ctrl_dump
// Run controller for the risc core: counts RUN cycles, halts on timeout,
// self-loop or external request, drains the pipeline, freezes the core and
// streams every architectural register out over a valid/ready port.
//
// Build option: define RUN_CTRL_SELFLOOP_EN to include the self-loop detector
// (cause 2). Without it pc_i / pc_valid_i are unused.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   pc_i, pc_valid_i  : retiring PC stream (self-loop detection)
//   halt_i            : external halt request
//   fetch_hold_o      : core inserts bubbles instead of fetching
//   core_stall_o      : core clock-enable low, all core state frozen
//   rf_raddr_o        : register-file debug read address
//   rf_rdata_i        : combinational read data for rf_raddr_o
//   dump_valid_o/ready_i, dump_idx_o, dump_data_o : register dump stream
//   done_o            : dump complete, sticky until reset
//   halt_cause_o      : 0 none, 1 timeout, 2 self-loop, 3 external
//   cycle_count_o     : cycles spent in RUN, saturating
// -----------------------------------------------------------------------------
module run_ctrl_dump
  import run_ctrl_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NREGS        = 32,
  parameter int unsigned MAX_CYCLES   = 500,
  parameter int unsigned DRAIN_CYCLES = 5,
  parameter int unsigned SELF_LOOP_N  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [XLEN-1:0]          pc_i,
  input  logic                     pc_valid_i,
  input  logic                     halt_i,
  output logic                     fetch_hold_o,
  output logic                     core_stall_o,
  output logic [$clog2(NREGS)-1:0] rf_raddr_o,
  input  logic [XLEN-1:0]          rf_rdata_i,
  output logic                     dump_valid_o,
  input  logic                     dump_ready_i,
  output logic [$clog2(NREGS)-1:0] dump_idx_o,
  output logic [XLEN-1:0]          dump_data_o,
  output logic                     done_o,
  output logic [1:0]               halt_cause_o,
  output logic [31:0]              cycle_count_o
);

  localparam int unsigned   IW          = $clog2(NREGS);
  localparam int unsigned   DW          = idx_width(DRAIN_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX    = IW'(NREGS - 1);
  localparam logic [31:0]   TIMEOUT_CNT = 32'(MAX_CYCLES - 1);

  run_state_e    state_q,      state_d;
  halt_cause_e   cause_q,      cause_d;
  logic [31:0]   cycle_cnt_q,  cycle_cnt_d;
  logic [DW-1:0] drain_cnt_q,  drain_cnt_d;
  logic [IW-1:0] idx_q,        idx_d;
  logic          fetch_hold_q, fetch_hold_d;
  logic          core_stall_q, core_stall_d;
  logic          dump_valid_q, dump_valid_d;
  logic          done_q,       done_d;

  logic          loop_hit;
  logic          timeout_hit;
  logic          halt_req;

`ifdef RUN_CTRL_SELFLOOP_EN
  pc_loop_detect #(
    .XLEN       (XLEN),
    .SELF_LOOP_N(SELF_LOOP_N)
  ) u_pc_loop_detect (
    .clk       (clk),
    .reset     (reset),
    .pc_i      (pc_i),
    .pc_valid_i(pc_valid_i),
    .loop_hit  (loop_hit)
  );
`else
  logic unused_pc;
  assign unused_pc = ^{pc_valid_i, pc_i};
  assign loop_hit  = 1'b0;
`endif

  assign timeout_hit = (cycle_cnt_q == TIMEOUT_CNT);
  assign halt_req    = halt_i || loop_hit || timeout_hit;

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    cycle_cnt_d = cycle_cnt_q;
    drain_cnt_d = drain_cnt_q;
    idx_d       = idx_q;

    unique case (state_q)
      RUN: begin
        // The halt cycle itself is still counted, so the count freezes at
        // its value on the halt edge.
        if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (halt_req) begin
          if (halt_i)        cause_d = EXTERNAL;
          else if (loop_hit) cause_d = SELFLOOP;
          else               cause_d = TIMEOUT;
          drain_cnt_d = '0;
          idx_d       = '0;
          state_d     = (DRAIN_CYCLES == 0) ? DUMP : DRAIN;
        end
      end
      DRAIN: begin
        if (32'(drain_cnt_q) + 32'd1 == DRAIN_CYCLES) state_d = DUMP;
        else drain_cnt_d = drain_cnt_q + DW'(1);
      end
      DUMP: begin
        if (dump_ready_i) begin
          if (idx_q == LAST_IDX) state_d = DONE;
          else idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
      end
      default: state_d = RUN;
    endcase

    // Outputs are registered: decode them from the next state.
    fetch_hold_d = (state_d != RUN);
    core_stall_d = (state_d == DUMP) || (state_d == DONE);
    dump_valid_d = (state_d == DUMP);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      cause_q      <= NONE;
      cycle_cnt_q  <= '0;
      drain_cnt_q  <= '0;
      idx_q        <= '0;
      fetch_hold_q <= 1'b0;
      core_stall_q <= 1'b0;
      dump_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      cycle_cnt_q  <= cycle_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      idx_q        <= idx_d;
      fetch_hold_q <= fetch_hold_d;
      core_stall_q <= core_stall_d;
      dump_valid_q <= dump_valid_d;
      done_q       <= done_d;
    end
  end

  assign fetch_hold_o  = fetch_hold_q;
  assign core_stall_o  = core_stall_q;
  assign dump_valid_o  = dump_valid_q;
  assign done_o        = done_q;
  assign halt_cause_o  = cause_q;
  assign cycle_count_o = cycle_cnt_q;
  assign rf_raddr_o    = idx_q;
  assign dump_idx_o    = idx_q;
  // x0 is architecturally zero regardless of what the debug port returns.
  assign dump_data_o   = (dump_valid_q && (idx_q != '0)) ? rf_rdata_i : '0;

endmodule

// File: tb/tb_run_ctrl_dump.sv
// Two instances share stimulus: u_dut drains for 5 cycles, u_dut_nd has no
// drain phase. Expectations come from a phase/queue model of the run rules.
module tb_run_ctrl_dump;

  localparam int NR   = 32;
  localparam int MAXC = 20;
  localparam int SLN  = 4;
`ifdef RUN_CTRL_SELFLOOP_EN
  localparam bit SL_EN = 1'b1;
`else
  localparam bit SL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_valid, halt, ready;

  logic [1:0]       fh, cs, dv, dn;
  logic [1:0][4:0]  ra, di;
  logic [1:0][31:0] rd, dd, cc;
  logic [1:0][1:0]  hc;
  logic [31:0]      rf [NR];

  assign rd[0] = rf[ra[0]];
  assign rd[1] = rf[ra[1]];

  always #5 clk = ~clk;

  run_ctrl_dump #(.XLEN(32), .NREGS(NR), .MAX_CYCLES(MAXC), .DRAIN_CYCLES(5),
                  .SELF_LOOP_N(SLN)) u_dut (
    .clk(clk), .reset(reset), .pc_i(pc), .pc_valid_i(pc_valid), .halt_i(halt),
    .fetch_hold_o(fh[0]), .core_stall_o(cs[0]), .rf_raddr_o(ra[0]),
    .rf_rdata_i(rd[0]), .dump_valid_o(dv[0]), .dump_ready_i(ready),
    .dump_idx_o(di[0]), .dump_data_o(dd[0]), .done_o(dn[0]),
    .halt_cause_o(hc[0]), .cycle_count_o(cc[0]));

  run_ctrl_dump #(.XLEN(32), .NREGS(NR), .MAX_CYCLES(MAXC), .DRAIN_CYCLES(0),
                  .SELF_LOOP_N(SLN)) u_dut_nd (
    .clk(clk), .reset(reset), .pc_i(pc), .pc_valid_i(pc_valid), .halt_i(halt),
    .fetch_hold_o(fh[1]), .core_stall_o(cs[1]), .rf_raddr_o(ra[1]),
    .rf_rdata_i(rd[1]), .dump_valid_o(dv[1]), .dump_ready_i(ready),
    .dump_idx_o(di[1]), .dump_data_o(dd[1]), .done_o(dn[1]),
    .halt_cause_o(hc[1]), .cycle_count_o(cc[1]));

  // Model: phase 0 run, 1 drain, 2 dump, 3 done
  int          m_phase [2];
  int          m_dl    [2];
  logic [31:0] m_cnt   [2];
  int          m_cause [2];
  int          m_idx   [2];
  logic [31:0] hist [$];

  int n_assert = 0;
  int n_fail   = 0;
  int rmode    = 0;
  int pat      = 0;
  bit rand_pc  = 0;
  bit rand_halt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Self-loop: this valid PC equals each of the previous SLN-1 valid PCs.
  function automatic bit self_hit();
    if (!SL_EN || !pc_valid || hist.size() < SLN - 1) return 1'b0;
    for (int i = 0; i < SLN - 1; i++)
      if (hist[hist.size() - 1 - i] != pc) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit sl;
    sl = self_hit();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_phase[k] = 0; m_dl[k] = 0; m_cnt[k] = 0; m_cause[k] = 0; m_idx[k] = 0;
      end else begin
        case (m_phase[k])
          0: begin
            int c;
            c = halt ? 3 : sl ? 2 : (m_cnt[k] == MAXC - 1) ? 1 : 0;
            if (m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k] = m_cnt[k] + 1;
            if (c != 0) begin
              m_cause[k] = c;
              m_idx[k]   = 0;
              if (k == 0) begin m_phase[k] = 1; m_dl[k] = 5; end
              else m_phase[k] = 2;
            end
          end
          1: begin
            m_dl[k]--;
            if (m_dl[k] == 0) m_phase[k] = 2;
          end
          2: if (ready) begin
            if (m_idx[k] == NR - 1) m_phase[k] = 3;
            else m_idx[k]++;
          end
          default: ;
        endcase
      end
    end
    if (reset) hist.delete();
    else if (pc_valid) begin
      hist.push_back(pc);
      if (hist.size() > SLN - 1) void'(hist.pop_front());
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("fetch_hold%0d", k), 32'(fh[k]), 32'(m_phase[k] != 0));
      chk($sformatf("core_stall%0d", k), 32'(cs[k]), 32'(m_phase[k] >= 2));
      chk($sformatf("dump_valid%0d", k), 32'(dv[k]), 32'(m_phase[k] == 2));
      chk($sformatf("done%0d", k),       32'(dn[k]), 32'(m_phase[k] == 3));
      chk($sformatf("cause%0d", k),      32'(hc[k]), 32'(m_cause[k]));
      chk($sformatf("count%0d", k),      cc[k],      m_cnt[k]);
      if (m_phase[k] == 2) begin
        chk($sformatf("idx%0d", k),   32'(di[k]), 32'(m_idx[k]));
        chk($sformatf("raddr%0d", k), 32'(ra[k]), 32'(m_idx[k]));
        chk($sformatf("data%0d", k),  dd[k], (m_idx[k] == 0) ? 32'd0 : rf[m_idx[k]]);
      end else if (m_phase[k] == 0) begin
        chk($sformatf("run_idx%0d", k),  32'(di[k]), 32'd0);
        chk($sformatf("run_data%0d", k), dd[k],      32'd0);
      end
    end
  endtask

  task automatic drive();
    case (rmode)
      0: ready = 1'b1;
      1: begin ready = (pat % 4 == 0) || (pat % 4 == 3); pat++; end
      default: ready = 1'($urandom_range(0, 1));
    endcase
    if (rand_pc) begin
      pc_valid = 1'($urandom_range(0, 1));
      pc       = 32'($urandom_range(0, 2) * 4);
    end
    if (rand_halt) halt = ($urandom_range(0, 39) == 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; pc_valid = 1'b0; halt = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    while (!(m_phase[0] == 3 && m_phase[1] == 3) && n < budget) begin
      drive();
      step();
      n++;
    end
    chk("done_within_budget", 32'(dn), 32'b11);
  endtask

  initial begin
    reset = 1'b1; pc = '0; pc_valid = 1'b0; halt = 1'b0; ready = 1'b1;
    for (int i = 0; i < NR; i++) rf[i] = $urandom;
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_dl[k] = 0; m_cnt[k] = 0; m_cause[k] = 0; m_idx[k] = 0;
    end

    // Timeout with ready held high
    do_reset();
    rmode = 0;
    run_until_done(200);
    chk("to_cause", 32'(hc[0]), 32'd1);
    chk("to_count", cc[0], 32'd20);
    chk("to_cause_nd", 32'(hc[1]), 32'd1);

    // Self-loop PC sequence
    do_reset();
    begin
      logic [31:0] seq [6] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8};
      for (int i = 0; i < 6; i++) begin
        pc = seq[i]; pc_valid = 1'b1; ready = 1'b1;
        step();
      end
    end
    pc_valid = 1'b0;
    run_until_done(200);
    chk("sl_cause", 32'(hc[0]), SL_EN ? 32'd2 : 32'd1);
    chk("sl_count", cc[0], SL_EN ? 32'd6 : 32'd20);

    // External halt on the same edge as the timeout
    do_reset();
    for (int i = 0; i < MAXC - 1; i++) step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    run_until_done(200);
    chk("sim_cause", 32'(hc[0]), 32'd3);
    chk("sim_count", cc[0], 32'd20);

    // Backpressure, x0 forced to zero, reset mid-dump
    do_reset();
    rf[0] = 32'hDEADBEEF;
    rmode = 1; pat = 0;
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("drain_fh", 32'(fh[0]), 32'd1);
    chk("drain_cs", 32'(cs[0]), 32'd0);
    chk("nodrain_dv", 32'(dv[1]), 32'd1);
    chk("nodrain_x0", dd[1], 32'd0);
    begin
      int n;
      n = 0;
      while (!(m_phase[0] == 2 && m_idx[0] == 10) && n < 200) begin
        drive();
        step();
        n++;
      end
    end
    chk("reach_idx10", 32'(di[0]), 32'd10);
    do_reset();

    // Randomized runs
    rmode = 2; rand_pc = 1; rand_halt = 1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NR; i++) rf[i] = $urandom;
      do_reset();
      run_until_done(400);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
